// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the parametrised register bank.
//   mode_t  : per-register access mode codes (3 bits, packed into REG_MODE)
//   state_t : bus handshake FSM state
//   byte_lane / mode_rd_err / mode_wr_err : small decode helpers
package reg_bank_pkg;

  typedef enum logic [2:0] {
    MODE_NONE = 3'd0,
    MODE_RO   = 3'd1,
    MODE_RW   = 3'd2,
    MODE_RWE  = 3'd3,
    MODE_WO   = 3'd4,
    MODE_W1C  = 3'd5,
    MODE_RC   = 3'd6
  } mode_t;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  // Expands one byte-enable bit into an 8-bit lane mask.
  function automatic logic [7:0] byte_lane(input logic b);
    return {8{b}};
  endfunction

  // A read of this mode is answered with err=1.
  function automatic logic mode_rd_err(input mode_t m);
    return (m == MODE_NONE) || (m == MODE_WO);
  endfunction

  // A write to this mode is answered with err=1.
  function automatic logic mode_wr_err(input mode_t m);
    return (m == MODE_NONE) || (m == MODE_RO);
  endfunction

endpackage

// File: rtl/reg_bank_cell.sv
// One DW-bit register whose behaviour is fixed by the MODE parameter.
// Ports:
//   clk, rstb        : clock, synchronous active-low reset
//   bus_wr / bus_rd  : one-cycle strobes for an accepted bus write / read
//   wmask, wdata     : byte-expanded write mask and write data
//   hw_we, hw_data   : hardware load (RWE) / live value (RO)
//   hw_set           : per-bit event set (W1C/RC)
//   q                : value presented to the fabric
//   rd_val           : value a bus read of this register returns
//   evt              : sticky event bits feeding the irq summary
module reg_bank_cell
  import reg_bank_pkg::*;
#(
  parameter int              DW        = 16,
  parameter mode_t           MODE      = MODE_RW,
  parameter logic [DW-1:0]   RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          bus_wr,
  input  logic          bus_rd,
  input  logic [DW-1:0] wmask,
  input  logic [DW-1:0] wdata,
  input  logic          hw_we,
  input  logic [DW-1:0] hw_data,
  input  logic [DW-1:0] hw_set,
  output logic [DW-1:0] q,
  output logic [DW-1:0] rd_val,
  output logic [DW-1:0] evt
);

  logic [DW-1:0] r;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      case (MODE)
        MODE_RW, MODE_RWE, MODE_WO: r <= RESET_VAL;
        default:                    r <= '0;
      endcase
    end else begin
      case (MODE)
        MODE_RW, MODE_WO: begin
          if (bus_wr) r <= (r & ~wmask) | (wdata & wmask);
        end
        MODE_RWE: begin
          // Hardware load takes the whole word over a same-cycle bus write.
          if (hw_we)       r <= hw_data;
          else if (bus_wr) r <= (r & ~wmask) | (wdata & wmask);
        end
        MODE_W1C: begin
          // Set is OR-ed in after the clear, so a same-cycle set survives.
          r <= (r & ~(bus_wr ? (wdata & wmask) : '0)) | hw_set;
        end
        MODE_RC: begin
          r <= (bus_rd ? '0 : r) | hw_set;
        end
        default: r <= '0;
      endcase
    end
  end

  always_comb begin
    q      = '0;
    rd_val = '0;
    evt    = '0;
    case (MODE)
      MODE_RO:            rd_val = hw_data;
      MODE_RW, MODE_RWE: begin q = r; rd_val = r; end
      MODE_WO:            q = r;
      MODE_W1C, MODE_RC: begin q = r; rd_val = r; evt = r; end
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_bank_param.sv
// Parametrised control/status register bank with an addressed req/ack bus.
// Handshake: the master raises req with we/addr/wdata/be stable and holds it
// until ack. In S_IDLE a sampled req performs the access and moves to S_ACK;
// S_ACK drives ack=1 (with registered rdata/err) for exactly one cycle and
// returns to S_IDLE. rdata/err read as 0 whenever ack=0.
// Ports:
//   clk, rstb                 : clock, synchronous active-low reset
//   req, we, addr, wdata, be  : bus request
//   rdata, ack, err           : bus response
//   hw_we, hw_data, hw_set    : hardware-side inputs, one slice per register
//   q                         : register contents to the fabric
//   irq                       : registered OR of all W1C/RC bits
//   state_dbg                 : current handshake FSM state
module reg_bank_param
  import reg_bank_pkg::*;
#(
  parameter int                  NREGS     = 12,
  parameter int                  DW        = 16,
  parameter int                  AW        = 6,
  parameter logic [NREGS*3-1:0]  REG_MODE  = {NREGS{3'(MODE_RW)}},
  parameter logic [NREGS*DW-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                req,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [DW-1:0]       wdata,
  input  logic [DW/8-1:0]     be,
  output logic [DW-1:0]       rdata,
  output logic                ack,
  output logic                err,
  input  logic [NREGS-1:0]    hw_we,
  input  logic [NREGS*DW-1:0] hw_data,
  input  logic [NREGS*DW-1:0] hw_set,
  output logic [NREGS*DW-1:0] q,
  output logic                irq,
  output state_t              state_dbg
);

  state_t             state;
  logic               accept;
  logic [DW-1:0]      wmask;
  logic [NREGS-1:0]   bus_wr;
  logic [NREGS-1:0]   bus_rd;
  logic [DW-1:0]      cell_rd  [NREGS];
  logic [DW-1:0]      cell_evt [NREGS];
  logic               in_range;
  mode_t              sel_mode;
  logic [DW-1:0]      sel_rd;
  logic               acc_err;
  logic               evt_any;

  assign accept    = (state == S_IDLE) && req;
  assign state_dbg = state;

  always_comb begin
    wmask = '0;
    for (int i = 0; i < DW/8; i++) wmask[i*8 +: 8] = byte_lane(be[i]);
  end

  // Address decode: an address with no matching register selects nothing,
  // so it produces no strobes and reads back as MODE_NONE / zero.
  always_comb begin
    bus_wr   = '0;
    bus_rd   = '0;
    in_range = 1'b0;
    sel_mode = MODE_NONE;
    sel_rd   = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (addr == AW'(i)) begin
        in_range  = 1'b1;
        sel_mode  = mode_t'(REG_MODE[i*3 +: 3]);
        sel_rd    = cell_rd[i];
        bus_wr[i] = accept && we;
        bus_rd[i] = accept && !we;
      end
    end
  end

  assign acc_err = !in_range || (we ? mode_wr_err(sel_mode) : mode_rd_err(sel_mode));

  always_comb begin
    evt_any = 1'b0;
    for (int i = 0; i < NREGS; i++) evt_any = evt_any | (|cell_evt[i]);
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_cell
    reg_bank_cell #(
      .DW        (DW),
      .MODE      (mode_t'(REG_MODE[g*3 +: 3])),
      .RESET_VAL (RESET_VAL[g*DW +: DW])
    ) u_cell (
      .clk     (clk),
      .rstb    (rstb),
      .bus_wr  (bus_wr[g]),
      .bus_rd  (bus_rd[g]),
      .wmask   (wmask),
      .wdata   (wdata),
      .hw_we   (hw_we[g]),
      .hw_data (hw_data[g*DW +: DW]),
      .hw_set  (hw_set[g*DW +: DW]),
      .q       (q[g*DW +: DW]),
      .rd_val  (cell_rd[g]),
      .evt     (cell_evt[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= S_IDLE;
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      irq   <= 1'b0;
    end else begin
      irq <= evt_any;
      case (state)
        S_IDLE: begin
          if (req) begin
            state <= S_ACK;
            ack   <= 1'b1;
            err   <= acc_err;
            rdata <= we ? '0 : sel_rd;
          end
        end
        S_ACK: begin
          state <= S_IDLE;
          ack   <= 1'b0;
          err   <= 1'b0;
          rdata <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_param.sv
module tb_reg_bank_param;
  import reg_bank_pkg::*;

  localparam int NREGS = 12;
  localparam int DW    = 16;
  localparam int AW    = 6;
  // reg11..reg0: RW RW RW RO WO RC W1C RWE RW RW NONE RW
  localparam logic [NREGS*3-1:0] MODES = {3'd2, 3'd2, 3'd2, 3'd1, 3'd4, 3'd6,
                                          3'd5, 3'd3, 3'd2, 3'd2, 3'd0, 3'd2};
  localparam logic [NREGS*DW-1:0] RVALS = {16'h0000, 16'h0000, 16'h0000, 16'hDEAD,
                                           16'h7777, 16'h0000, 16'h0000, 16'h4444,
                                           16'h1234, 16'hA5A5, 16'h0000, 16'h0000};

  logic                clk = 1'b0;
  logic                rstb;
  logic                req;
  logic                we;
  logic [AW-1:0]       addr;
  logic [DW-1:0]       wdata;
  logic [DW/8-1:0]     be;
  logic [DW-1:0]       rdata;
  logic                ack;
  logic                err;
  logic [NREGS-1:0]    hw_we;
  logic [NREGS*DW-1:0] hw_data;
  logic [NREGS*DW-1:0] hw_set;
  logic [NREGS*DW-1:0] q;
  logic                irq;
  state_t              state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  reg_bank_param #(
    .NREGS(NREGS), .DW(DW), .AW(AW), .REG_MODE(MODES), .RESET_VAL(RVALS)
  ) dut (
    .clk(clk), .rstb(rstb), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .rdata(rdata), .ack(ack), .err(err), .hw_we(hw_we),
    .hw_data(hw_data), .hw_set(hw_set), .q(q), .irq(irq), .state_dbg(state_dbg)
  );

  // Clock / reset timing: 10 ns period; inputs change and outputs are
  // sampled 1 ns after each rising edge.
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] qreg(input int i);
    return q[i*DW +: DW];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one bus transaction, waits (bounded) for ack, then one more cycle
  // to confirm the ack pulse is single-cycle and rdata falls back to 0.
  // Hardware strobes are cleared once the access edge has consumed them.
  task automatic bus(input string tag, input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [DW/8-1:0] b,
                     output logic [DW-1:0] rd, output logic e);
    int lat;
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    lat = 0; rd = '0; e = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      hw_we  = '0;
      hw_set = '0;
      if (ack) begin
        lat = i; rd = rdata; e = err;
        break;
      end
    end
    req = 1'b0; we = 1'b0;
    chk({tag, "_lat"}, 64'(lat), 64'd1);
    @(posedge clk); #1;
    chk({tag, "_ackpulse"}, {63'd0, ack}, 64'd0);
    chk({tag, "_rdata_idle"}, 64'(rdata), 64'd0);
  endtask

  task automatic bus_read(input string tag, input logic [AW-1:0] a,
                          input logic [DW-1:0] exp_rd, input logic exp_err);
    logic [DW-1:0] rd;
    logic e;
    bus(tag, 1'b0, a, '0, '0, rd, e);
    chk({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
    chk({tag, "_err"}, {63'd0, e}, {63'd0, exp_err});
  endtask

  task automatic bus_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW/8-1:0] b, input logic exp_err);
    logic [DW-1:0] rd;
    logic e;
    bus(tag, 1'b1, a, d, b, rd, e);
    chk({tag, "_err"}, {63'd0, e}, {63'd0, exp_err});
  endtask

  initial begin
    rstb = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    hw_we = '0; hw_data = '0; hw_set = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {63'd0, ack}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_irq", {63'd0, irq}, 64'd0);
    chk("rst_state", {63'd0, state_dbg}, {63'd0, S_IDLE});
    chk("rst_q2", 64'(qreg(2)), 64'hA5A5);
    chk("rst_q5_w1c", 64'(qreg(5)), 64'h0);
    chk("rst_q6_rc", 64'(qreg(6)), 64'h0);
    chk("rst_q8_ro", 64'(qreg(8)), 64'h0);
    rstb = 1'b1;

    bus_read("rd_reg2", 6'd2, 16'hA5A5, 1'b0);

    // Byte-lane write, then a held request to check 2-cycle throughput.
    bus_write("wr_reg3_lo", 6'd3, 16'hFFFF, 2'b01, 1'b0);
    bus_read("rd_reg3", 6'd3, 16'h12FF, 1'b0);
    req = 1'b1; we = 1'b0; addr = 6'd3; be = '0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("held_ack_c%0d", c), {63'd0, ack}, {63'd0, c[0]});
      if (c == 3) chk("held_rdata", 64'(rdata), 64'h12FF);
    end
    req = 1'b0;
    @(posedge clk); #1;

    // RWE: same-cycle hardware load beats the bus write.
    hw_we[4] = 1'b1;
    hw_data[4*DW +: DW] = 16'hBEEF;
    bus_write("rwe_both", 6'd4, 16'h0001, 2'b11, 1'b0);
    chk("rwe_hw_wins", 64'(qreg(4)), 64'hBEEF);
    bus_write("rwe_bus", 6'd4, 16'h0001, 2'b11, 1'b0);
    chk("rwe_bus_q", 64'(qreg(4)), 64'h0001);

    // W1C and the registered irq.
    hw_set[5*DW +: DW] = 16'h0011;
    @(posedge clk); #1;
    hw_set = '0;
    chk("w1c_set_q", 64'(qreg(5)), 64'h0011);
    chk("w1c_irq_lag", {63'd0, irq}, 64'd0);
    @(posedge clk); #1;
    chk("w1c_irq_on", {63'd0, irq}, 64'd1);
    bus_write("w1c_clr0", 6'd5, 16'h0001, 2'b11, 1'b0);
    chk("w1c_clr0_q", 64'(qreg(5)), 64'h0010);
    chk("w1c_clr0_irq", {63'd0, irq}, 64'd1);
    hw_set[5*DW +: DW] = 16'h0010;
    bus_write("w1c_setwins", 6'd5, 16'h0010, 2'b11, 1'b0);
    chk("w1c_setwins_q", 64'(qreg(5)), 64'h0010);
    bus_write("w1c_clr4", 6'd5, 16'h0010, 2'b11, 1'b0);
    chk("w1c_clr4_q", 64'(qreg(5)), 64'h0000);
    chk("w1c_irq_off", {63'd0, irq}, 64'd0);

    // RC: read returns the pre-clear value.
    hw_set[6*DW +: DW] = 16'h0300;
    @(posedge clk); #1;
    hw_set = '0;
    chk("rc_set_q", 64'(qreg(6)), 64'h0300);
    bus_read("rc_rd1", 6'd6, 16'h0300, 1'b0);
    chk("rc_cleared", 64'(qreg(6)), 64'h0000);
    bus_read("rc_rd2", 6'd6, 16'h0000, 1'b0);
    hw_set[6*DW +: DW] = 16'h0001;
    bus_read("rc_rd_set", 6'd6, 16'h0000, 1'b0);
    chk("rc_setwins_q", 64'(qreg(6)), 64'h0001);
    bus_read("rc_rd3", 6'd6, 16'h0001, 1'b0);
    chk("rc_rd3_q", 64'(qreg(6)), 64'h0000);

    // Error responses and no-effect accesses.
    bus_write("wo_wr", 6'd7, 16'h00AB, 2'b11, 1'b0);
    chk("wo_q", 64'(qreg(7)), 64'h00AB);
    bus_read("wo_rd", 6'd7, 16'h0000, 1'b1);
    hw_data[8*DW +: DW] = 16'hCAFE;
    bus_write("ro_wr", 6'd8, 16'hFFFF, 2'b11, 1'b1);
    chk("ro_q", 64'(qreg(8)), 64'h0);
    bus_read("ro_rd", 6'd8, 16'hCAFE, 1'b0);
    bus_read("oor_rd", 6'd12, 16'h0000, 1'b1);
    bus_write("oor_wr", 6'd12, 16'hFFFF, 2'b11, 1'b1);
    chk("oor_q0", 64'(qreg(0)), 64'h0);
    bus_read("none_rd", 6'd1, 16'h0000, 1'b1);
    bus_write("be0_wr", 6'd0, 16'hFFFF, 2'b00, 1'b0);
    bus_read("be0_rd", 6'd0, 16'h0000, 1'b0);
    bus_write("be_hi_wr", 6'd0, 16'hABCD, 2'b10, 1'b0);
    bus_read("be_hi_rd", 6'd0, 16'hAB00, 1'b0);

    // Reset right after a write is accepted.
    req = 1'b1; we = 1'b1; addr = 6'd3; wdata = 16'hAAAA; be = 2'b11;
    @(posedge clk); #1;
    rstb = 1'b0; req = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ack", {63'd0, ack}, 64'd0);
    chk("midrst_q3", 64'(qreg(3)), 64'h1234);
    chk("midrst_q4", 64'(qreg(4)), 64'h4444);
    chk("midrst_q7", 64'(qreg(7)), 64'h7777);
    chk("midrst_q0", 64'(qreg(0)), 64'h0000);
    rstb = 1'b1;
    bus_read("post_rst_rd3", 6'd3, 16'h1234, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
